etapa_wb_vec: RTL and testbench
===============================

Name: etapa_WB_vec

Overview:
- Writeback stage of the vector pipeline; the receiving end of the execute stage's result interface (alu_result, dir_dest).
- Buffers ALU results in a 2-entry FIFO and arbitrates them against memory load returns for a single write port.
- Owns an 8 x 32-bit vector register file, whose two read ports feed the execute stage's vector_a / vector_b operands.
- Exports a pending-write mask for hazard detection in decode.

Parameters:
DATA_W, 32, vector word width (4 lanes x 8 bits)
ADDR_W, 3, register address width
NREG, 8, number of vector registers (2**ADDR_W)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
exe_valid  in  1  execute stage presents a result
exe_ready  out  1  stage can accept a result this cycle
alu_result  in  DATA_W  result from execute stage
dir_dest  in  ADDR_W  destination register of the result
wb_en_in  in  1  instruction writes a register (0 = drop result)
mem_valid  in  1  load data returning this cycle (cannot be stalled)
mem_data  in  DATA_W  load data
mem_dest  in  ADDR_W  load destination register
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
wb_valid  out  1  a register write happened on the last edge
wb_dest  out  ADDR_W  register written on the last edge
wb_data  out  DATA_W  data written on the last edge
busy_mask  out  NREG  one-hot OR of the destinations of valid FIFO entries

Behaviour:
- Reset, asynchronous and active-high:
  - all registers cleared to 0
  - FIFO cleared (count = 0)
  - wb_valid = 0, wb_dest = 0, wb_data = 0
  - busy_mask = 0, exe_ready = 1 as soon as reset deasserts
  - Reset asserted mid-operation discards buffered results; there is no drain.
- Accept rule:
  - A transfer happens when exe_valid && exe_ready at the rising edge.
  - exe_ready = (count < 2), derived from registered count only; no combinational path from inputs.
  - A transfer with wb_en_in = 0 is consumed and discarded (no FIFO entry). It still requires exe_ready.
- FIFO: 2 entries of {dest, data}, head/tail pointers that wrap modulo 2, count 0..2.
- Write arbitration, one register-file write per cycle:
  - mem_valid = 1: write mem_data to mem_dest. The FIFO head is not popped.
  - Otherwise, if count > 0: write the head entry and pop it.
  - Otherwise: no write.
- Simultaneous events:
  - Push and pop in the same cycle leave count unchanged. A push into an empty FIFO is not written until the next cycle (minimum ALU latency: 1 edge into FIFO, 1 edge into register file).
  - mem_valid together with count = 2 holds exe_ready = 0; no overflow is possible.
  - Continuous mem_valid starves the FIFO; that is legal and there is no timeout.
- wb_valid / wb_dest / wb_data: registered copy of the write performed on that edge; wb_valid is 0 in cycles with no write.
- Reads are asynchronous from the register array; a write becomes visible after the edge (without FORWARD_EN).
- busy_mask updates on the edge together with the FIFO and reflects post-edge contents. A load to a busy register does not clear its bit.
- All 8 registers are writable; register 0 is not hardwired.

Optional Feature:
- Macro: WB_FORWARD_EN
- Defined: each read port returns the data being written this cycle when its address matches the write destination (mem or FIFO head, per the arbitration above); otherwise array contents. Same-cycle write-to-read bypass.
- Undefined: read ports return array contents only. Decode must stall on busy_mask and on any same-cycle write.

Test Plan:
- Reset then idle: read all 8 addresses -> all 0; exe_ready = 1, busy_mask = 8'h00, wb_valid = 0.
- Single ALU push: alu_result = 32'hA1B2C3D4, dir_dest = 5, wb_en_in = 1 at edge 0 -> busy_mask = 8'h20 after edge 0; wb_valid = 1, wb_dest = 5, wb_data = 32'hA1B2C3D4 after edge 1; rd_addr_a = 5 returns 32'hA1B2C3D4 after edge 1; busy_mask = 0.
- Backpressure: mem_valid held 1 for 4 cycles (mem_dest = 1, mem_data = 32'h11111111) while pushing dest 2 and dest 3 -> exe_ready = 0 after the 2nd push, busy_mask = 8'h0C; after mem_valid drops, reg 2 then reg 3 written on consecutive edges, in order.
- Drop: exe_valid = 1, wb_en_in = 0, dir_dest = 4, data 32'hFFFFFFFF -> accepted, reg 4 unchanged (0), busy_mask unchanged, no wb_valid pulse.
- Reset mid-operation: two entries buffered (count = 2), assert reset asynchronously between edges -> exe_ready = 1, busy_mask = 0, buffered writes never appear on wb_*.
- WB_FORWARD_EN: mem_valid = 1, mem_dest = 6, mem_data = 32'h0F0F0F0F, rd_addr_b = 6 in the same cycle -> rd_data_b = 32'h0F0F0F0F before the edge. Macro undefined -> old value 0 before the edge.

Source files
------------

// File: rtl/etapa_wb_vec.sv
// Vector writeback stage: 2-entry ALU result FIFO, mem/ALU write arbiter, 8x32 RF.
// Define WB_FORWARD_EN for same-cycle write-to-read bypass on both read ports.
module etapa_wb_vec #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] dir_dest,
    input  logic              wb_en_in,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic [NREG-1:0]   busy_mask
);

    logic [DATA_W-1:0] rf     [NREG];
    logic [ADDR_W-1:0] q_dest [2];
    logic [DATA_W-1:0] q_data [2];
    logic              head;
    logic              tail;
    logic [1:0]        count;

    logic              push;
    logic              pop;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_dest;
    logic [DATA_W-1:0] wr_data;

    assign exe_ready = (count != 2'd2);
    assign push      = exe_valid && exe_ready && wb_en_in;
    // Loads cannot stall, so they always win the write port.
    assign pop       = !mem_valid && (count != 2'd0);
    assign wr_en     = mem_valid || pop;
    assign wr_dest   = mem_valid ? mem_dest : q_dest[head];
    assign wr_data   = mem_valid ? mem_data : q_data[head];

`ifdef WB_FORWARD_EN
    assign rd_data_a = (wr_en && rd_addr_a == wr_dest) ? wr_data : rf[rd_addr_a];
    assign rd_data_b = (wr_en && rd_addr_b == wr_dest) ? wr_data : rf[rd_addr_b];
`else
    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];
`endif

    always_comb begin
        busy_mask = '0;
        if (count != 2'd0) busy_mask[q_dest[head]] = 1'b1;
        if (count == 2'd2) busy_mask[q_dest[~head]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                q_dest[i] <= '0;
                q_data[i] <= '0;
            end
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= 2'd0;
            wb_valid <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else begin
            if (wr_en) begin
                rf[wr_dest] <= wr_data;
                wb_dest     <= wr_dest;
                wb_data     <= wr_data;
            end
            wb_valid <= wr_en;
            if (push) begin
                q_dest[tail] <= dir_dest;
                q_data[tail] <= alu_result;
                tail         <= ~tail;
            end
            if (pop) head <= ~head;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_etapa_wb_vec.sv
// Bench for etapa_wb_vec: directed cases plus random traffic vs a queue model.
// Build with +define+WB_FORWARD_EN to exercise the bypass variant.
module tb_etapa_wb_vec;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_valid;
    logic        exe_ready;
    logic [31:0] alu_result;
    logic [2:0]  dir_dest;
    logic        wb_en_in;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [2:0]  mem_dest;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [31:0] wb_data;
    logic [7:0]  busy_mask;

    etapa_wb_vec dut (
        .clk(clk), .reset(reset),
        .exe_valid(exe_valid), .exe_ready(exe_ready),
        .alu_result(alu_result), .dir_dest(dir_dest), .wb_en_in(wb_en_in),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_dest(mem_dest),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t        fifo_m[$];
    logic [31:0] rf_m [8];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mask_m();
        logic [7:0] m = '0;
        foreach (fifo_m[i]) m[fifo_m[i].dest] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        fifo_m.delete();
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(input logic ev, input logic [31:0] d, input logic [2:0] dst,
                         input logic we, input logic mv, input logic [31:0] md,
                         input logic [2:0] mdst, input logic [2:0] ra, input logic [2:0] rb);
        logic        wv;
        logic        acc;
        logic [2:0]  wdst;
        logic [31:0] wdat;
        logic [31:0] ea;
        logic [31:0] eb;
        exe_valid = ev; alu_result = d; dir_dest = dst; wb_en_in = we;
        mem_valid = mv; mem_data = md; mem_dest = mdst;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
        chk("exe_ready", 32'(exe_ready), 32'(fifo_m.size() < 2));
        wv = 1'b0; wdst = '0; wdat = '0;
        if (mv) begin
            wv = 1'b1; wdst = mdst; wdat = md;
        end else if (fifo_m.size() > 0) begin
            wv = 1'b1; wdst = fifo_m[0].dest; wdat = fifo_m[0].data;
        end
        ea = rf_m[ra];
        eb = rf_m[rb];
`ifdef WB_FORWARD_EN
        if (wv && wdst == ra) ea = wdat;
        if (wv && wdst == rb) eb = wdat;
`endif
        chk("rd_data_a", rd_data_a, ea);
        chk("rd_data_b", rd_data_b, eb);
        acc = ev && (fifo_m.size() < 2);
        if (wv) rf_m[wdst] = wdat;
        if (!mv && fifo_m.size() > 0) void'(fifo_m.pop_front());
        if (acc && we) fifo_m.push_back('{dest: dst, data: d});
        @(negedge clk);
        chk("wb_valid", 32'(wb_valid), 32'(wv));
        if (wv) begin
            chk("wb_dest", 32'(wb_dest), 32'(wdst));
            chk("wb_data", wb_data, wdat);
        end
        chk("busy_mask", 32'(busy_mask), 32'(mask_m()));
    endtask

    task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, ra, rb);
    endtask

    initial begin
        reset = 1'b1;
        exe_valid = 0; alu_result = 0; dir_dest = 0; wb_en_in = 0;
        mem_valid = 0; mem_data = 0; mem_dest = 0; rd_addr_a = 0; rd_addr_b = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_exe_ready", 32'(exe_ready), 32'd1);
        chk("rst_busy", 32'(busy_mask), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);

        // Forward/no-forward on a fresh reg 6
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 32'h0F0F0F0F, 3'd6, 3'd0, 3'd6);
        for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));

        // Single push
        cycle(1'b1, 32'hA1B2C3D4, 3'd5, 1'b1, 1'b0, '0, '0, 3'd5, 3'd0);
        chk("push_busy", 32'(busy_mask), 32'h20);
        idle(3'd5, 3'd5);
        chk("push_wb_dest", 32'(wb_dest), 32'd5);
        idle(3'd5, 3'd1);
        chk("push_rd", rd_data_a, 32'hA1B2C3D4);

        // Backpressure under continuous loads
        cycle(1'b1, 32'h22222222, 3'd2, 1'b1, 1'b1, 32'h11111111, 3'd1, 3'd2, 3'd3);
        cycle(1'b1, 32'h33333333, 3'd3, 1'b1, 1'b1, 32'h11111111, 3'd1, 3'd2, 3'd3);
        chk("bp_busy", 32'(busy_mask), 32'h0C);
        cycle(1'b1, 32'h44444444, 3'd4, 1'b1, 1'b1, 32'h11111111, 3'd1, 3'd2, 3'd3);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 32'h11111111, 3'd1, 3'd2, 3'd3);
        idle(3'd2, 3'd3);
        chk("bp_first", 32'(wb_dest), 32'd2);
        idle(3'd2, 3'd3);
        chk("bp_second", 32'(wb_dest), 32'd3);

        // Dropped result
        cycle(1'b1, 32'hFFFFFFFF, 3'd4, 1'b0, 1'b0, '0, '0, 3'd4, 3'd4);
        idle(3'd4, 3'd4);
        chk("drop_reg4", rd_data_a, 32'd0);

        // Reset with two buffered entries
        cycle(1'b1, 32'h55555555, 3'd6, 1'b1, 1'b1, 32'h77777777, 3'd0, 3'd0, 3'd0);
        cycle(1'b1, 32'h66666666, 3'd7, 1'b1, 1'b1, 32'h77777777, 3'd0, 3'd0, 3'd0);
        chk("pre_rst_busy", 32'(busy_mask), 32'hC0);
        exe_valid = 0; mem_valid = 0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(exe_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy_mask), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) idle(3'(i + 4), 3'(i));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 3'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                  $urandom, 3'($urandom), 3'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 3; i++) idle(3'(i), 3'(i + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
